// File: rtl/bus_tracked.sv
// bus_tracked: N-host / M-device simulation interconnect with in-order
// outstanding-transaction tracking and address-decode error responses.
// Optional feature macro: BUS_TRACKED_RR_EN selects round-robin arbitration;
// when undefined, arbitration is fixed priority with host 0 highest.
module bus_tracked #(
  parameter int unsigned NrHosts        = 3,
  parameter int unsigned NrDevices      = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NrHosts-1:0]                      host_req_i,
  output logic [NrHosts-1:0]                      host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                      host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
  output logic [NrHosts-1:0]                      host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
  output logic [NrHosts-1:0]                      host_err_o,
  output logic [NrDevices-1:0]                    device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]  device_addr_o,
  output logic [NrDevices-1:0]                    device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]   device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]     device_wdata_o,
  input  logic [NrDevices-1:0]                    device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata_i,
  input  logic [NrDevices-1:0]                    device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_mask
);

  localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned PtrW     = $clog2(MaxOutstanding);
  localparam int unsigned CntW     = PtrW + 1;

  typedef struct packed {
    logic [HostIdxW-1:0] host;
    logic [DevIdxW-1:0]  device;
    logic                decerr;
  } entry_t;

  entry_t                  fifo_q [MaxOutstanding];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    arb_valid, dec_hit, full, grant, pop;
  logic [HostIdxW-1:0]     arb_idx;
  logic [DevIdxW-1:0]      dec_idx;
  logic [AddressWidth-1:0] sel_addr;
  entry_t                  head, push_entry;

`ifdef BUS_TRACKED_RR_EN
  logic [HostIdxW-1:0] rr_ptr_q, rr_ptr_d;

  function automatic logic [HostIdxW-1:0] rr_wrap(input int unsigned v);
    return HostIdxW'(v % NrHosts);
  endfunction
`endif

  // Pick one requesting host: round-robin from rr_ptr, or lowest index first
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
`ifdef BUS_TRACKED_RR_EN
      if (!arb_valid && host_req_i[rr_wrap(32'(rr_ptr_q) + i)]) begin
        arb_valid = 1'b1;
        arb_idx   = rr_wrap(32'(rr_ptr_q) + i);
      end
`else
      if (!arb_valid && host_req_i[i]) begin
        arb_valid = 1'b1;
        arb_idx   = HostIdxW'(i);
      end
`endif
    end
  end

  // Address decode of the arbitrated host; lowest matching device wins
  always_comb begin
    sel_addr = host_addr_i[arb_idx];
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dec_hit && ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        dec_hit = 1'b1;
        dec_idx = DevIdxW'(d);
      end
    end
  end

  // Grant/pop qualification; a full FIFO blocks grant even when popping
  always_comb begin
    full       = (count_q == CntW'(MaxOutstanding));
    grant      = arb_valid && !full && !rst_i;
    head       = fifo_q[rd_ptr_q];
    pop        = (count_q != '0) && !rst_i && (head.decerr || device_rvalid_i[head.device]);
    push_entry = '{host: arb_idx, device: dec_idx, decerr: !dec_hit};
  end

  // Forward the granted request to the decoded device, zero elsewhere
  always_comb begin
    host_gnt_o     = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (grant) begin
      host_gnt_o[arb_idx] = 1'b1;
    end
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (grant && dec_hit && (dec_idx == DevIdxW'(d))) begin
        device_req_o[d]   = 1'b1;
        device_addr_o[d]  = sel_addr;
        device_we_o[d]    = host_we_i[arb_idx];
        device_be_o[d]    = host_be_i[arb_idx];
        device_wdata_o[d] = host_wdata_i[arb_idx];
      end
    end
  end

  // Route the head entry's response back to its host
  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (pop && (head.host == HostIdxW'(h))) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = head.decerr ? 1'b1 : device_err_i[head.device];
        host_rdata_o[h]  = head.decerr ? '0 : device_rdata_i[head.device];
      end
    end
  end

  // Tracking FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d = grant ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({grant, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
`ifdef BUS_TRACKED_RR_EN
    rr_ptr_d = grant ? rr_wrap(32'(arb_idx) + 32'd1) : rr_ptr_q;
`endif
  end

  // Pointer, occupancy and arbitration state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef BUS_TRACKED_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef BUS_TRACKED_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Tracking entry storage; validity is governed by count_q alone
  always_ff @(posedge clk_i) begin
    if (grant) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: doc/bus_tracked.md
# bus_tracked

Parametrised N-host / M-device simulation interconnect with in-order outstanding-transaction tracking, address-decode error responses and optional round-robin arbitration. It replaces the single-outstanding, fixed-priority bus in Ibex simulation top-levels, connecting core instruction/data ports and test-utility hosts to RAM and utility devices. At most one request is granted per cycle. Responses return to hosts strictly in grant order.

## Interface
- NrHosts, 3: number of host ports, 1..8.
- NrDevices, 2: number of device ports, 1..8.
- DataWidth, 32: data bus width.
- AddressWidth, 32: address width.
- MaxOutstanding, 4: tracking FIFO depth, power of 2, 2..16.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- host_req_i / host_gnt_o  in/out  [NrHosts] x 1  request / same-cycle grant.
- host_addr_i  in  [NrHosts] x AddressWidth  byte address.
- host_we_i, host_be_i, host_wdata_i  in  [NrHosts] x 1, DataWidth/8, DataWidth  write controls.
- host_rvalid_o, host_rdata_o, host_err_o  out  [NrHosts] x 1, DataWidth, 1  response.
- device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o  out  [NrDevices] x ...  forwarded request.
- device_rvalid_i, device_rdata_i, device_err_i  in  [NrDevices] x ...  device response.
- cfg_device_addr_base, cfg_device_addr_mask  in  [NrDevices] x AddressWidth  decode window.

## Operation
- Decode: device d matches when (addr & mask[d]) == base[d]. The lowest matching index wins. If no device matches, the request is a decode error.
- Arbitration selects one requesting host per cycle. Grant is blocked entirely while FIFO count == MaxOutstanding, even if a pop occurs in the same cycle.
- On grant:
  - host_gnt_o[h] = 1 and the request is forwarded on the decoded device port (device_req_o = 1 for exactly that device).
  - A tracking entry {host, device, decerr} is pushed.
  - A decode-error grant drives no device_req_o.
- Response path, head entry only:
  - Normal entry: when device_rvalid_i[head.device] = 1, drive host_rvalid_o[head.host] = 1, with rdata and err taken from that device. The entry is popped.
  - Decode-error entry: host_rvalid_o = 1, host_err_o = 1 and host_rdata_o = 0 in the first cycle the entry is at the head (at least 1 cycle after grant). The entry is popped.
  - device_rvalid_i from any device other than the head's device is ignored.
  - device_rvalid_i with an empty FIFO is ignored.
- Outputs with no valid response: host_rvalid_o = 0, host_rdata_o = 0, host_err_o = 0.
- Device-facing buses (addr, we, be, wdata) are driven with the granted host's values on the selected device and 0 elsewhere.
- Push and pop in the same cycle are both allowed: count is unchanged and pointers advance modulo MaxOutstanding.

## Timing
- Grant is combinational in the request cycle, with zero added request latency. A host must hold its request until granted.
- Minimum response latency is device latency + 0. A 1-cycle RAM gives rvalid in the cycle after grant.
- Reset values:
  - FIFO empty, count = 0, pointers = 0, round-robin pointer = 0.
  - All *_o outputs are 0 during and after reset until a request arrives.
- Reset mid-operation: all outstanding entries are discarded. Later device responses for discarded entries are ignored because the FIFO is empty.
- Wrap-around: pointers roll from MaxOutstanding-1 to 0 with no bubble.

## Configuration
- BUS_TRACKED_RR_EN defined: round-robin arbitration.
  - The search starts at rr_ptr and wraps through NrHosts.
  - rr_ptr becomes granted host + 1 (mod NrHosts), updated only on a grant.
- BUS_TRACKED_RR_EN undefined: fixed priority, lowest host index highest. rr_ptr is absent.

## Test plan
- Single host 0 reads 0x100 from a 1-cycle RAM (base 0x0, mask ~0xFFFF) holding 0xDEADBEEF -> gnt same cycle; next cycle host_rvalid_o[0] = 1, rdata 0xDEADBEEF, err 0.
- Host 1 reads unmapped 0x40000 -> gnt, no device_req_o; next cycle host_rvalid_o[1] = 1, err 1, rdata 0.
- Hosts 0, 1 and 2 request continuously for 6 cycles:
  - With BUS_TRACKED_RR_EN: grant order 0,1,2,0,1,2.
  - Without it: 0,0,0,0,0,0.
- A device that withholds rvalid while one host issues 6 back-to-back requests with MaxOutstanding = 4 -> exactly 4 grants, gnt stays 0 until the first response. Then one grant per pop, with no grant in the pop cycle itself while full.
- Interleaved RAM read then decode error then RAM read -> responses delivered in grant order. The decode-error response waits behind the first RAM response.
- rst_i asserted for 1 cycle with 3 entries outstanding, and RAM rvalid arriving the next cycle -> no host_rvalid_o. Count = 0 and the next request is granted immediately.
